// File: rtl/vivaz_bus_ctrl.sv
// Vivaz display bus controller.
// Sequences the display reset pin after power-up or a soft reset, then serves 16-bit
// command/data writes on an 8080-style strobe interface. It can also park the bus to wait
// for a tearing-effect (TE) rising edge, with a timeout if no edge arrives.
// All state-carrying logic shares one 24-bit down-counter, and every output is a flop.

module vivaz_bus_ctrl #(
  parameter int unsigned WR_LOW_CYC     = 2,
  parameter int unsigned WR_HIGH_CYC    = 2,
  parameter int unsigned RST_LOW_CYC    = 1000,
  parameter int unsigned RST_WAIT_CYC   = 5000,
  parameter int unsigned TE_TIMEOUT_CYC = 1000000
) (
  input  logic        clk,
  input  logic        main_reset,
  input  logic        sw_reset,
  input  logic        cmd_valid,
  input  logic        cmd_is_data,
  input  logic [15:0] cmd_word,
  output logic        cmd_ready,
  input  logic        frame_req,
  output logic        frame_go,
  output logic        te_timeout,
  output logic        init_done,
  input  logic        vivaz_TE,
  output logic        vivaz_RESET,
  output logic        vivaz_RS,
  output logic        vivaz_WR,
  output logic [15:0] vivaz_D015
);

  localparam logic [2:0] StRstLow  = 3'd0;
  localparam logic [2:0] StRstWait = 3'd1;
  localparam logic [2:0] StIdle    = 3'd2;
  localparam logic [2:0] StWrLow   = 3'd3;
  localparam logic [2:0] StWrHigh  = 3'd4;
  localparam logic [2:0] StWaitTe  = 3'd5;

  localparam logic [23:0] WrLowCnt     = 24'(WR_LOW_CYC);
  localparam logic [23:0] WrHighCnt    = 24'(WR_HIGH_CYC);
  localparam logic [23:0] RstLowCnt    = 24'(RST_LOW_CYC);
  localparam logic [23:0] RstWaitCnt   = 24'(RST_WAIT_CYC);
  localparam logic [23:0] TeTimeoutCnt = 24'(TE_TIMEOUT_CYC);

  logic [2:0]  state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic        init_done_q, init_done_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        frame_go_q, frame_go_d;
  logic        te_timeout_q, te_timeout_d;
  logic        reset_q, reset_d;
  logic        wr_q, wr_d;
  logic        rs_q, rs_d;
  logic [15:0] data_q, data_d;

  logic te_meta_q, te_sync_q, te_prev_q;
  logic te_rise;
  logic cnt_last;
  logic [23:0] cnt_dec;

  // TE is asynchronous to clk: two flops to resolve metastability, a third to find the edge.
  always_ff @(posedge clk or negedge main_reset) begin
    if (!main_reset) begin
      te_meta_q <= 1'b0;
      te_sync_q <= 1'b0;
      te_prev_q <= 1'b0;
    end else begin
      te_meta_q <= vivaz_TE;
      te_sync_q <= te_meta_q;
      te_prev_q <= te_sync_q;
    end
  end

  assign te_rise  = te_sync_q & ~te_prev_q;
  // Treat 0 like 1 so an out-of-range count can never wrap into a 2^24-cycle stall.
  assign cnt_last = (cnt_q <= 24'd1);
  assign cnt_dec  = cnt_q - 24'd1;

  // Next-state and next-output logic; outputs are computed one cycle ahead and registered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q | (frame_req & init_done_q);
    init_done_d  = init_done_q;
    reset_d      = reset_q;
    wr_d         = wr_q;
    rs_d         = rs_q;
    data_d       = data_q;
    frame_go_d   = 1'b0;
    te_timeout_d = 1'b0;

    if (sw_reset) begin
      // Abort whatever is running, including a write with WR low.
      state_d     = StRstLow;
      cnt_d       = RstLowCnt;
      reset_d     = 1'b0;
      wr_d        = 1'b1;
      init_done_d = 1'b0;
      pend_d      = 1'b0;
    end else begin
      case (state_q)
        StRstLow: begin
          reset_d = 1'b0;
          wr_d    = 1'b1;
          if (cnt_last) begin
            state_d = StRstWait;
            cnt_d   = RstWaitCnt;
            reset_d = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end

        StRstWait: begin
          if (cnt_last) begin
            state_d     = StIdle;
            init_done_d = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end

        StIdle: begin
          // A pending frame request beats any offered word; cmd_ready is already low then.
          if (pend_q) begin
            state_d = StWaitTe;
            cnt_d   = TeTimeoutCnt;
            // A request arriving in this very cycle is kept for a later wait.
            pend_d  = frame_req & init_done_q;
          end else if (cmd_valid && cmd_ready_q) begin
            state_d = StWrLow;
            cnt_d   = WrLowCnt;
            wr_d    = 1'b0;
            data_d  = cmd_word;
            rs_d    = cmd_is_data;
          end
        end

        StWrLow: begin
          if (cnt_last) begin
            state_d = StWrHigh;
            cnt_d   = WrHighCnt;
            wr_d    = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end

        StWrHigh: begin
          if (cnt_last) begin
            state_d = StIdle;
          end else begin
            cnt_d = cnt_dec;
          end
        end

        StWaitTe: begin
          // An edge in the final cycle still counts as a frame, not a timeout.
          if (te_rise) begin
            state_d    = StIdle;
            frame_go_d = 1'b1;
          end else if (cnt_last) begin
            state_d      = StIdle;
            te_timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_dec;
          end
        end

        default: begin
          // Unused encodings recover through a full display reset.
          state_d     = StRstLow;
          cnt_d       = RstLowCnt;
          reset_d     = 1'b0;
          wr_d        = 1'b1;
          init_done_d = 1'b0;
          pend_d      = 1'b0;
        end
      endcase
    end

    cmd_ready_d = (state_d == StIdle) & init_done_d & ~pend_d;
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge main_reset) begin
    if (!main_reset) begin
      state_q      <= StRstLow;
      cnt_q        <= RstLowCnt;
      pend_q       <= 1'b0;
      init_done_q  <= 1'b0;
      cmd_ready_q  <= 1'b0;
      frame_go_q   <= 1'b0;
      te_timeout_q <= 1'b0;
      reset_q      <= 1'b0;
      wr_q         <= 1'b1;
      rs_q         <= 1'b0;
      data_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      init_done_q  <= init_done_d;
      cmd_ready_q  <= cmd_ready_d;
      frame_go_q   <= frame_go_d;
      te_timeout_q <= te_timeout_d;
      reset_q      <= reset_d;
      wr_q         <= wr_d;
      rs_q         <= rs_d;
      data_q       <= data_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign frame_go    = frame_go_q;
  assign te_timeout  = te_timeout_q;
  assign init_done   = init_done_q;
  assign vivaz_RESET = reset_q;
  assign vivaz_RS    = rs_q;
  assign vivaz_WR    = wr_q;
  assign vivaz_D015  = data_q;

endmodule

// File: tb/tb_vivaz_bus_ctrl.sv
// Directed bench for vivaz_bus_ctrl with short timing parameters.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.

module tb_vivaz_bus_ctrl;

  logic        clk;
  logic        main_reset;
  logic        sw_reset;
  logic        cmd_valid;
  logic        cmd_is_data;
  logic [15:0] cmd_word;
  logic        cmd_ready;
  logic        frame_req;
  logic        frame_go;
  logic        te_timeout;
  logic        init_done;
  logic        vivaz_TE;
  logic        vivaz_RESET;
  logic        vivaz_RS;
  logic        vivaz_WR;
  logic [15:0] vivaz_D015;

  int checks = 0;
  int errors = 0;

  vivaz_bus_ctrl #(
    .WR_LOW_CYC    (2),
    .WR_HIGH_CYC   (1),
    .RST_LOW_CYC   (4),
    .RST_WAIT_CYC  (3),
    .TE_TIMEOUT_CYC(10)
  ) dut (
    .clk        (clk),
    .main_reset (main_reset),
    .sw_reset   (sw_reset),
    .cmd_valid  (cmd_valid),
    .cmd_is_data(cmd_is_data),
    .cmd_word   (cmd_word),
    .cmd_ready  (cmd_ready),
    .frame_req  (frame_req),
    .frame_go   (frame_go),
    .te_timeout (te_timeout),
    .init_done  (init_done),
    .vivaz_TE   (vivaz_TE),
    .vivaz_RESET(vivaz_RESET),
    .vivaz_RS   (vivaz_RS),
    .vivaz_WR   (vivaz_WR),
    .vivaz_D015 (vivaz_D015)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    logic seen;
    logic ok;

    main_reset  = 1'b1;
    sw_reset    = 1'b0;
    cmd_valid   = 1'b0;
    cmd_is_data = 1'b0;
    cmd_word    = 16'h0000;
    frame_req   = 1'b0;
    vivaz_TE    = 1'b0;
    #2 main_reset = 1'b0;
    step();
    step();

    // Reset values
    chk("rst_RESET", vivaz_RESET, 0);
    chk("rst_WR", vivaz_WR, 1);
    chk("rst_RS", vivaz_RS, 0);
    chk("rst_D", vivaz_D015, 0);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_frame_go", frame_go, 0);
    chk("rst_te_timeout", te_timeout, 0);

    // Power-up: RESET low 4 edges, init_done 3 edges later
    main_reset = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (vivaz_RESET !== 1'b0) ok = 1'b0;
    end
    chk("pwr_reset_low_3", ok, 1);
    step();
    chk("pwr_reset_high", vivaz_RESET, 1);
    chk("pwr_init_not_yet", init_done, 0);
    step();
    step();
    chk("pwr_init_2", init_done, 0);
    step();
    chk("pwr_init_done", init_done, 1);
    chk("pwr_ready", cmd_ready, 1);

    // Back-to-back writes: 0x1234 command, then 0xABCD data
    cmd_valid   = 1'b1;
    cmd_word    = 16'h1234;
    cmd_is_data = 1'b0;
    step();
    chk("w1_WR_low", vivaz_WR, 0);
    chk("w1_D", vivaz_D015, 16'h1234);
    chk("w1_RS", vivaz_RS, 0);
    chk("w1_ready", cmd_ready, 0);
    cmd_word    = 16'hABCD;
    cmd_is_data = 1'b1;
    step();
    chk("w1_WR_low2", vivaz_WR, 0);
    chk("w1_D_stable", vivaz_D015, 16'h1234);
    chk("w1_RS_stable", vivaz_RS, 0);
    step();
    chk("w1_WR_high", vivaz_WR, 1);
    chk("w1_high_ready", cmd_ready, 0);
    step();
    chk("w1_idle_ready", cmd_ready, 1);
    chk("w1_idle_WR", vivaz_WR, 1);
    step();
    chk("w2_WR_low", vivaz_WR, 0);
    chk("w2_D", vivaz_D015, 16'hABCD);
    chk("w2_RS", vivaz_RS, 1);
    cmd_valid = 1'b0;
    step();
    chk("w2_WR_low2", vivaz_WR, 0);
    chk("w2_D_stable", vivaz_D015, 16'hABCD);
    step();
    chk("w2_WR_high", vivaz_WR, 1);
    step();
    chk("w2_idle_ready", cmd_ready, 1);

    // Frame sync: TE rises 5 cycles after the request
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    chk("fs_ready_pend", cmd_ready, 0);
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cmd_ready !== 1'b0 || frame_go !== 1'b0) ok = 1'b0;
    end
    chk("fs_wait_quiet", ok, 1);
    vivaz_TE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      step();
      if (frame_go === 1'b1) seen = 1'b1;
      else if (cmd_ready !== 1'b0) ok = 1'b0;
    end
    chk("fs_frame_go_seen", seen, 1);
    chk("fs_ready_low_wait", ok, 1);
    chk("fs_ready_after", cmd_ready, 1);
    step();
    chk("fs_frame_go_pulse", frame_go, 0);
    chk("fs_no_timeout", te_timeout, 0);

    // Timeout: TE held low
    vivaz_TE  = 1'b0;
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    chk("to_enter_ready", cmd_ready, 0);
    ok = 1'b1;
    for (int i = 0; i < 9; i++) begin
      step();
      if (te_timeout !== 1'b0 || frame_go !== 1'b0 || cmd_ready !== 1'b0) ok = 1'b0;
    end
    chk("to_quiet_9", ok, 1);
    step();
    chk("to_pulse", te_timeout, 1);
    chk("to_no_frame_go", frame_go, 0);
    chk("to_ready", cmd_ready, 1);
    step();
    chk("to_pulse_end", te_timeout, 0);

    // TE edge outside WAIT_TE is ignored
    vivaz_TE = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      if (frame_go !== 1'b0) ok = 1'b0;
    end
    chk("te_idle_ignored", ok, 1);
    vivaz_TE = 1'b0;
    step();
    step();
    step();

    // Collision: frame_req during WR_LOW with cmd_valid held
    cmd_valid   = 1'b1;
    cmd_word    = 16'h5555;
    cmd_is_data = 1'b0;
    step();
    chk("co_WR_low", vivaz_WR, 0);
    frame_req = 1'b1;
    cmd_word  = 16'h6666;
    step();
    frame_req = 1'b0;
    chk("co_WR_low2", vivaz_WR, 0);
    chk("co_D_stable", vivaz_D015, 16'h5555);
    step();
    chk("co_WR_high", vivaz_WR, 1);
    step();
    chk("co_idle_not_ready", cmd_ready, 0);
    step();
    chk("co_wait_WR", vivaz_WR, 1);
    chk("co_wait_D", vivaz_D015, 16'h5555);
    vivaz_TE = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3 && !seen; i++) begin
      step();
      if (frame_go === 1'b1) seen = 1'b1;
    end
    chk("co_frame_go", seen, 1);
    chk("co_ready", cmd_ready, 1);
    step();
    chk("co_w2_WR_low", vivaz_WR, 0);
    chk("co_w2_D", vivaz_D015, 16'h6666);
    cmd_valid = 1'b0;
    vivaz_TE  = 1'b0;

    // Abort with sw_reset during WR_LOW, frame_req during reset is ignored
    sw_reset = 1'b1;
    step();
    sw_reset = 1'b0;
    chk("ab_WR", vivaz_WR, 1);
    chk("ab_RESET", vivaz_RESET, 0);
    chk("ab_init_done", init_done, 0);
    chk("ab_ready", cmd_ready, 0);
    frame_req = 1'b1;
    step();
    frame_req = 1'b0;
    step();
    step();
    chk("ab_reset_low_4", vivaz_RESET, 0);
    step();
    chk("ab_reset_high", vivaz_RESET, 1);
    step();
    step();
    chk("ab_init_2", init_done, 0);
    step();
    chk("ab_init_done", init_done, 1);
    chk("ab_ready_no_pend", cmd_ready, 1);
    step();
    chk("ab_still_idle", cmd_ready, 1);

    // Asynchronous reset mid-cycle
    #2 main_reset = 1'b0;
    #1;
    chk("ar_RESET", vivaz_RESET, 0);
    chk("ar_init_done", init_done, 0);
    chk("ar_ready", cmd_ready, 0);
    chk("ar_D", vivaz_D015, 0);
    chk("ar_WR", vivaz_WR, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
